// File: rtl/halflife_seq_ctrl_if.sv
// Control/status bundle between the half-life sequencer and its user/counter side.
// The master drives run commands; the slave (sequencer) drives counter load and status.
interface halflife_seq_ctrl_if #(
  parameter int W  = 4,
  parameter int PW = 8,
  parameter int HW = 4
);
  logic          start;
  logic          abort;
  logic          tick_en;
  logic [W-1:0]  init_qty;
  logic [W-1:0]  min_qty;
  logic [PW-1:0] half_period;
  logic          cnt_load;
  logic [W-1:0]  cnt_load_val;
  logic [W-1:0]  qty;
  logic [HW-1:0] halvings;
  logic [PW-1:0] remaining;
  logic          busy;
  logic          done;

  modport master (
    output start, abort, tick_en, init_qty, min_qty, half_period,
    input  cnt_load, cnt_load_val, qty, halvings, remaining, busy, done
  );

  modport slave (
    input  start, abort, tick_en, init_qty, min_qty, half_period,
    output cnt_load, cnt_load_val, qty, halvings, remaining, busy, done
  );
endinterface

// File: rtl/halflife_seq_ctrl.sv
// Half-life sequencer: loads a quantity into the counter, halves it once per
// half-period of time-base ticks, and stops at or below a live floor.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | one-cycle counter load of the captured start quantity
// RUN   | counting down ticks of the current half-life
// HALVE | one-cycle halving and counter reload
// DONE  | quantity at or below floor; results held
module halflife_seq_ctrl #(
  parameter int W  = 4,
  parameter int PW = 8,
  parameter int HW = 4
) (
  input  logic                clk,
  input  logic                rst,
  halflife_seq_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_HALVE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  qty_r;
  logic [W-1:0]  qty_half;
  logic [HW-1:0] halvings_r;
  logic [PW-1:0] remaining_r;
  logic [PW-1:0] period_r;

  assign qty_half = qty_r >> 1;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (bus.start) state_nxt = (bus.init_qty > bus.min_qty) ? S_LOAD : S_DONE;
      end
      S_LOAD:  state_nxt = S_RUN;
      S_RUN: begin
        if (bus.tick_en && (remaining_r == PW'(1))) state_nxt = S_HALVE;
      end
      S_HALVE: state_nxt = (qty_half <= bus.min_qty) ? S_DONE : S_RUN;
      default: state_nxt = S_IDLE;
    endcase
    if (bus.abort) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      qty_r       <= '0;
      halvings_r  <= '0;
      remaining_r <= '0;
      period_r    <= '0;
    end else if (bus.abort) begin
      remaining_r <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            qty_r       <= bus.init_qty;
            halvings_r  <= '0;
            remaining_r <= '0;
            // A zero period would never expire; run it as a single tick.
            period_r    <= (bus.half_period == '0) ? PW'(1) : bus.half_period;
          end
        end
        S_LOAD: begin
          halvings_r  <= '0;
          remaining_r <= period_r;
        end
        S_RUN: begin
          if (bus.tick_en && (remaining_r > PW'(1))) remaining_r <= remaining_r - PW'(1);
        end
        S_HALVE: begin
          qty_r       <= qty_half;
          if (halvings_r != '1) halvings_r <= halvings_r + HW'(1);
          remaining_r <= (state_nxt == S_DONE) ? '0 : period_r;
        end
        default: ;
      endcase
    end
  end

  assign bus.cnt_load     = (state == S_LOAD) || (state == S_HALVE);
  assign bus.cnt_load_val = (state == S_LOAD)  ? qty_r :
                            (state == S_HALVE) ? qty_half : '0;
  assign bus.qty          = qty_r;
  assign bus.halvings     = halvings_r;
  assign bus.remaining    = remaining_r;
  assign bus.busy         = (state == S_LOAD) || (state == S_RUN) || (state == S_HALVE);
  assign bus.done         = (state == S_DONE);

endmodule
